// File: rtl/bram_dwc_serializer_if.sv
// rtl/bram_dwc_serializer_if.sv - wide master request/response bundle plus narrow BRAM port
// slave: the converter's view; master: the environment driving requests and modelling the BRAM.
interface bram_dwc_serializer_if #(
  parameter int ADDR_BITW     = 32,
  parameter int MST_DATA_BITW = 128,
  parameter int SLV_DATA_BITW = 32
);
  localparam int MB = MST_DATA_BITW / 8;
  localparam int SB = SLV_DATA_BITW / 8;

  logic                     Req_SI;
  logic                     Gnt_SO;
  logic [ADDR_BITW-1:0]     Addr_DI;
  logic [MB-1:0]            WrEn_SI;
  logic [MST_DATA_BITW-1:0] Wr_DI;
  logic                     RspValid_SO;
  logic                     RspReady_SI;
  logic [MST_DATA_BITW-1:0] Rd_DO;

  logic                     Slv_En_SO;
  logic [ADDR_BITW-1:0]     Slv_Addr_DO;
  logic [SB-1:0]            Slv_WrEn_SO;
  logic [SLV_DATA_BITW-1:0] Slv_Wr_DO;
  logic [SLV_DATA_BITW-1:0] Slv_Rd_DI;

  modport slave (
    input  Req_SI, Addr_DI, WrEn_SI, Wr_DI, RspReady_SI, Slv_Rd_DI,
    output Gnt_SO, RspValid_SO, Rd_DO, Slv_En_SO, Slv_Addr_DO, Slv_WrEn_SO, Slv_Wr_DO
  );

  modport master (
    output Req_SI, Addr_DI, WrEn_SI, Wr_DI, RspReady_SI, Slv_Rd_DI,
    input  Gnt_SO, RspValid_SO, Rd_DO, Slv_En_SO, Slv_Addr_DO, Slv_WrEn_SO, Slv_Wr_DO
  );
endinterface

// File: rtl/bram_dwc_serializer.sv
// rtl/bram_dwc_serializer.sv - serializes one wide access into N narrow BRAM beats
// Read slices are gathered into one wide response; writes return the old contents.
module bram_dwc_serializer #(
  parameter int ADDR_BITW     = 32,
  parameter int MST_DATA_BITW = 128,
  parameter int SLV_DATA_BITW = 32
) (
  input logic                  Clk_CI,
  input logic                  Rst_RBI,
  bram_dwc_serializer_if.slave bus
);
  localparam int N      = MST_DATA_BITW / SLV_DATA_BITW;
  localparam int MB     = MST_DATA_BITW / 8;
  localparam int SB     = SLV_DATA_BITW / 8;
  localparam int N_LOG  = $clog2(N);
  localparam int MB_LOG = $clog2(MB);

  if (MST_DATA_BITW < 8 || (MST_DATA_BITW & (MST_DATA_BITW - 1)) != 0 ||
      SLV_DATA_BITW < 8 || (SLV_DATA_BITW & (SLV_DATA_BITW - 1)) != 0 ||
      MST_DATA_BITW <= SLV_DATA_BITW) begin : g_bad_width
    $fatal(1, "bram_dwc_serializer: widths must be powers of two >= 8 with MST > SLV");
  end

  localparam logic [N_LOG-1:0] K_ONE  = N_LOG'(1);
  localparam logic [N_LOG-1:0] K_LAST = N_LOG'(N - 1);

  typedef enum logic [1:0] {IDLE, BEAT, DRAIN, RESP} state_e;

  state_e                      state_q, state_d;
  logic [N_LOG-1:0]            k_q, k_d;
  logic [ADDR_BITW-MB_LOG-1:0] addr_q, addr_d;
  logic [MB-1:0]               wren_q, wren_d;
  logic [MST_DATA_BITW-1:0]    wr_q, wr_d;
  logic [MST_DATA_BITW-1:0]    rd_q, rd_d;
  logic [N_LOG-1:0]            cap_idx;
  logic                        unused_addr_bits;

  assign unused_addr_bits = ^bus.Addr_DI[MB_LOG-1:0];

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      wren_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wren_d  = wren_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    // Read data lags its beat by one cycle; in DRAIN k_q has wrapped to 0, so k-1 is N-1.
    cap_idx = k_q - K_ONE;

    bus.Gnt_SO      = 1'b0;
    bus.RspValid_SO = 1'b0;
    bus.Slv_En_SO   = 1'b0;
    bus.Slv_Addr_DO = '0;
    bus.Slv_WrEn_SO = '0;
    bus.Slv_Wr_DO   = '0;

    unique case (state_q)
      IDLE: begin
        bus.Gnt_SO = Rst_RBI;
        if (bus.Req_SI) begin
          addr_d  = bus.Addr_DI[ADDR_BITW-1:MB_LOG];
          wren_d  = bus.WrEn_SI;
          wr_d    = bus.Wr_DI;
          k_d     = '0;
          state_d = BEAT;
        end
      end
      BEAT: begin
        bus.Slv_En_SO   = 1'b1;
        bus.Slv_Addr_DO = ADDR_BITW'({addr_q, k_q}) << $clog2(SB);
        bus.Slv_WrEn_SO = wren_q[k_q*SB +: SB];
        bus.Slv_Wr_DO   = wr_q[k_q*SLV_DATA_BITW +: SLV_DATA_BITW];
        k_d             = k_q + K_ONE;
        if (k_q != '0) begin
          rd_d[cap_idx*SLV_DATA_BITW +: SLV_DATA_BITW] = bus.Slv_Rd_DI;
        end
        if (k_q == K_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        rd_d[cap_idx*SLV_DATA_BITW +: SLV_DATA_BITW] = bus.Slv_Rd_DI;
        state_d = RESP;
      end
      RESP: begin
        bus.RspValid_SO = 1'b1;
        if (bus.RspReady_SI) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Rd_DO = rd_q;
endmodule

// File: tb/tb_bram_dwc_serializer.sv
// tb/tb_bram_dwc_serializer.sv - randomized and directed bench with a wide-word memory model
module tb_bram_dwc_serializer;
  logic clk;
  logic rst_n;
  logic load;
  int   cyc;
  int   total;
  int   bad;

  bram_dwc_serializer_if #(.ADDR_BITW(32), .MST_DATA_BITW(128), .SLV_DATA_BITW(32)) bus ();

  bram_dwc_serializer #(.ADDR_BITW(32), .MST_DATA_BITW(128), .SLV_DATA_BITW(32)) dut (
    .Clk_CI (clk),
    .Rst_RBI(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Narrow BRAM: 64 words, one-cycle read latency, read-before-write.
  logic [31:0] mem      [64];
  logic [31:0] init_mem [64];
  logic [31:0] rd_reg;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
    end else if (bus.Slv_En_SO) begin
      rd_reg <= mem[bus.Slv_Addr_DO[7:2]];
      for (int b = 0; b < 4; b++)
        if (bus.Slv_WrEn_SO[b]) mem[bus.Slv_Addr_DO[7:2]][8*b +: 8] <= bus.Slv_Wr_DO[8*b +: 8];
    end
  end
  assign bus.Slv_Rd_DI = rd_reg;

  // Reference: memory viewed as 16 wide words.
  logic [127:0] ref_mem [16];

  function automatic logic [127:0] model_access(input logic [31:0] a, input logic [15:0] we,
                                                input logic [127:0] wd);
    logic [127:0] old;
    old = ref_mem[a[7:4]];
    for (int b = 0; b < 16; b++)
      if (we[b]) ref_mem[a[7:4]][8*b +: 8] = wd[8*b +: 8];
    return old;
  endfunction

  logic [31:0]  b_addr [$];
  logic [3:0]   b_we   [$];
  logic [31:0]  b_wd   [$];
  int           b_cyc  [$];
  int           hs_cyc;
  int           rsp_cyc;
  logic [127:0] rsp_rd;
  bit           rd_unstable;
  bit           gnt_early;

  // Entered and left at one time unit after a rising edge.
  task automatic run_access(input logic [31:0] a, input logic [15:0] we, input logic [127:0] wd,
                            input int ready_delay, input bit hold_req);
    int waited;
    int ready_cnt;
    bit done;
    b_addr.delete(); b_we.delete(); b_wd.delete(); b_cyc.delete();
    rsp_cyc = -1; rd_unstable = 0; gnt_early = 0;
    bus.Req_SI = 1'b1; bus.Addr_DI = a; bus.WrEn_SI = we; bus.Wr_DI = wd; bus.RspReady_SI = 1'b0;
    waited = 0;
    while (bus.Gnt_SO !== 1'b1 && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    total++;
    if (bus.Gnt_SO !== 1'b1) begin
      bad++;
      $display("FAIL grant_timeout: Gnt_SO=%b required 1", bus.Gnt_SO);
      bus.Req_SI = 1'b0;
      return;
    end
    hs_cyc = cyc;
    @(posedge clk); #1;
    bus.Req_SI  = hold_req;
    bus.Addr_DI = $urandom;
    bus.WrEn_SI = 16'($urandom);
    bus.Wr_DI   = {$urandom, $urandom, $urandom, $urandom};
    ready_cnt = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.Slv_En_SO === 1'b1) begin
        b_addr.push_back(bus.Slv_Addr_DO); b_we.push_back(bus.Slv_WrEn_SO);
        b_wd.push_back(bus.Slv_Wr_DO);     b_cyc.push_back(cyc - hs_cyc);
      end
      if (bus.RspValid_SO === 1'b1) begin
        if (rsp_cyc < 0) begin rsp_cyc = cyc - hs_cyc; rsp_rd = bus.Rd_DO; end
        if (bus.Rd_DO !== rsp_rd) rd_unstable = 1;
        if (bus.Gnt_SO !== 1'b0) gnt_early = 1;
        if (ready_cnt == ready_delay) begin
          bus.RspReady_SI = 1'b1;
          @(posedge clk); #1;
          bus.RspReady_SI = 1'b0;
          done = 1;
        end else ready_cnt++;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL rsp_timeout: no response handshake within 40 cycles of grant");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1;
    bus.Req_SI = 1'b1; bus.Addr_DI = '0; bus.WrEn_SI = '0; bus.Wr_DI = '0; bus.RspReady_SI = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.Gnt_SO !== 1'b0) begin bad++; $display("FAIL reset_gnt: got %b want 0", bus.Gnt_SO); end
    total++;
    if ({bus.RspValid_SO, bus.Rd_DO} !== 129'd0) begin
      bad++; $display("FAIL reset_rsp: valid=%b rd=%h want 0/0", bus.RspValid_SO, bus.Rd_DO);
    end
    total++;
    if ({bus.Slv_En_SO, bus.Slv_Addr_DO, bus.Slv_WrEn_SO, bus.Slv_Wr_DO} !== 69'd0) begin
      bad++; $display("FAIL reset_slv: en=%b addr=%h we=%h wd=%h want all 0",
                      bus.Slv_En_SO, bus.Slv_Addr_DO, bus.Slv_WrEn_SO, bus.Slv_Wr_DO);
    end
    load = 1'b0; bus.Req_SI = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.Gnt_SO !== 1'b1) begin bad++; $display("FAIL idle_gnt: got %b want 1", bus.Gnt_SO); end
  endtask

  task automatic test_read_n4();
    logic [127:0] exp;
    exp = model_access(32'h0, 16'h0, 128'h0);
    run_access(32'h0, 16'h0, 128'h0, 0, 1'b0);
    total++;
    if (b_addr.size() != 4) begin bad++; $display("FAIL read_beats: got %0d want 4", b_addr.size()); end
    for (int k = 0; k < b_addr.size(); k++) begin
      total++;
      if (b_addr[k] !== 32'(4 * k) || b_cyc[k] != k + 1) begin
        bad++; $display("FAIL read_beat%0d: addr=%h cyc=%0d want %h/%0d", k, b_addr[k], b_cyc[k], 4 * k, k + 1);
      end
    end
    total++;
    if (rsp_cyc != 6) begin bad++; $display("FAIL read_latency: got %0d want 6", rsp_cyc); end
    total++;
    if (rsp_rd !== 128'h44444444_33333333_22222222_11111111 || rsp_rd !== exp) begin
      bad++; $display("FAIL read_data: got %h want %h", rsp_rd, 128'h44444444_33333333_22222222_11111111);
    end
  endtask

  task automatic test_partial_write();
    logic [127:0] wd;
    logic [127:0] exp;
    wd = {$urandom, $urandom, 32'hDEADBEEF, $urandom};
    void'(model_access(32'h10, 16'h00F0, wd));
    run_access(32'h10, 16'h00F0, wd, 0, 1'b0);
    total++;
    if (b_we.size() != 4) begin bad++; $display("FAIL pw_beats: got %0d want 4", b_we.size()); end
    for (int k = 0; k < b_we.size(); k++) begin
      total++;
      if (b_we[k] !== ((k == 1) ? 4'hF : 4'h0) || b_addr[k] !== 32'(32'h10 + 4 * k)) begin
        bad++; $display("FAIL pw_beat%0d: we=%h addr=%h want %h/%h", k, b_we[k], b_addr[k],
                        (k == 1) ? 4'hF : 4'h0, 32'h10 + 4 * k);
      end
    end
    exp = model_access(32'h10, 16'h0, 128'h0);
    run_access(32'h10, 16'h0, 128'h0, 0, 1'b0);
    total++;
    if (rsp_rd !== exp || rsp_rd[63:32] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL pw_readback: got %h want %h", rsp_rd, exp);
    end
  endtask

  task automatic test_ignored_addr();
    logic [127:0] exp;
    exp = model_access(32'h1F, 16'h0, 128'h0);
    run_access(32'h1F, 16'h0, 128'h0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= b_addr.size() || b_addr[k] !== 32'(32'h10 + 4 * k)) begin
        bad++; $display("FAIL ign_addr_beat%0d: got %h want %h", k,
                        (k < b_addr.size()) ? b_addr[k] : 32'hx, 32'h10 + 4 * k);
      end
    end
    total++;
    if (rsp_rd !== exp) begin bad++; $display("FAIL ign_addr_data: got %h want %h", rsp_rd, exp); end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp;
    exp = model_access(32'h20, 16'h0, 128'h0);
    run_access(32'h20, 16'h0, 128'h0, 3, 1'b1);
    total++;
    if (bus.Gnt_SO !== 1'b1) begin bad++; $display("FAIL bp_regrant: got %b want 1", bus.Gnt_SO); end
    bus.Req_SI = 1'b0;
    total++;
    if (gnt_early) begin bad++; $display("FAIL bp_gnt_during_rsp: got 1 want 0"); end
    total++;
    if (rd_unstable || rsp_rd !== exp) begin
      bad++; $display("FAIL bp_data: unstable=%b rd=%h want 0/%h", rd_unstable, rsp_rd, exp);
    end
  endtask

  task automatic test_back_to_back();
    int first;
    logic [127:0] exp;
    void'(model_access(32'h30, 16'h0, 128'h0));
    run_access(32'h30, 16'h0, 128'h0, 0, 1'b1);
    first = hs_cyc;
    exp = model_access(32'h50, 16'h0, 128'h0);
    run_access(32'h50, 16'h0, 128'h0, 0, 1'b0);
    total++;
    if (hs_cyc - first != 7) begin bad++; $display("FAIL b2b_period: got %0d want 7", hs_cyc - first); end
    total++;
    if (rsp_rd !== exp) begin bad++; $display("FAIL b2b_data: got %h want %h", rsp_rd, exp); end
  endtask

  task automatic test_random();
    logic [31:0]  a;
    logic [15:0]  we;
    logic [127:0] wd;
    logic [127:0] exp;
    logic [127:0] sh;
    for (int t = 0; t < 24; t++) begin
      a  = $urandom;
      wd = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       we = 16'h0;
        1:       we = 16'($urandom);
        default: we = 16'hFFFF;
      endcase
      exp = model_access(a, we, wd);
      run_access(a, we, wd, $urandom_range(0, 3), 1'b0);
      total++;
      if (b_addr.size() != 4) begin bad++; $display("FAIL rnd%0d_beats: got %0d want 4", t, b_addr.size()); end
      for (int k = 0; k < b_addr.size() && k < 4; k++) begin
        sh = wd >> (32 * k);
        total++;
        if (b_addr[k] !== ((a & ~32'hF) + 32'(4 * k)) || b_we[k] !== 4'(we >> (4 * k)) ||
            b_wd[k] !== sh[31:0] || b_cyc[k] != k + 1) begin
          bad++; $display("FAIL rnd%0d_beat%0d: addr=%h we=%h wd=%h cyc=%0d want %h/%h/%h/%0d", t, k,
                          b_addr[k], b_we[k], b_wd[k], b_cyc[k],
                          (a & ~32'hF) + 32'(4 * k), 4'(we >> (4 * k)), sh[31:0], k + 1);
        end
      end
      total++;
      if (rsp_cyc != 6 || rsp_rd !== exp || rd_unstable) begin
        bad++; $display("FAIL rnd%0d_rsp: cyc=%0d rd=%h unstable=%b want 6/%h/0", t, rsp_cyc, rsp_rd,
                        rd_unstable, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] wd;
    logic [127:0] exp;
    bit           saw_valid;
    wd = {$urandom, $urandom, $urandom, $urandom};
    bus.Req_SI = 1'b1; bus.Addr_DI = 32'h40; bus.WrEn_SI = 16'hFFFF; bus.Wr_DI = wd;
    @(posedge clk); #1;
    bus.Req_SI = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if (bus.Slv_En_SO !== 1'b1 || bus.Slv_Addr_DO !== 32'h48) begin
      bad++; $display("FAIL rm_beat2: en=%b addr=%h want 1/00000048", bus.Slv_En_SO, bus.Slv_Addr_DO);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.Slv_En_SO, bus.Slv_WrEn_SO, bus.Gnt_SO} !== 6'd0) begin
      bad++; $display("FAIL rm_drop: en=%b we=%h gnt=%b want 0/0/0", bus.Slv_En_SO, bus.Slv_WrEn_SO, bus.Gnt_SO);
    end
    saw_valid = 0;
    repeat (3) begin @(negedge clk); if (bus.RspValid_SO !== 1'b0) saw_valid = 1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.RspValid_SO !== 1'b0) saw_valid = 1; end
    @(posedge clk); #1;
    total++;
    if (saw_valid) begin bad++; $display("FAIL rm_no_rsp: RspValid_SO seen 1 want 0"); end
    total++;
    if (bus.Gnt_SO !== 1'b1) begin bad++; $display("FAIL rm_regrant: got %b want 1", bus.Gnt_SO); end
    void'(model_access(32'h40, 16'h00FF, wd));
    exp = model_access(32'h40, 16'h0, 128'h0);
    run_access(32'h40, 16'h0, 128'h0, 0, 1'b0);
    total++;
    if (rsp_rd !== exp) begin bad++; $display("FAIL rm_partial: got %h want %h", rsp_rd, exp); end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
    init_mem[0] = 32'h11111111; init_mem[1] = 32'h22222222;
    init_mem[2] = 32'h33333333; init_mem[3] = 32'h44444444;
    for (int j = 0; j < 16; j++)
      ref_mem[j] = {init_mem[4*j+3], init_mem[4*j+2], init_mem[4*j+1], init_mem[4*j]};
    test_reset();
    test_read_n4();
    test_partial_write();
    test_ignored_addr();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bram_dwc_serializer.md
# bram_dwc_serializer

Sequential down-converting BRAM data width converter: a wide master issues one word-sized access over a request/grant interface, and the block serializes it into N consecutive accesses on a narrow BRAM port. It also gathers the N narrow read words into one wide response. It sits between a wide datapath (e.g. a 128-bit DMA engine) and a narrow BRAM port. This is the direction that cannot be done combinationally.

## Interface
- ADDR_BITW, 32, byte-address width; identical on both sides.
- MST_DATA_BITW, 128, master data width.
- SLV_DATA_BITW, 32, BRAM data width.
- Elaboration-time `$fatal` if any of these fail:
  - both widths are powers of two and at least 8;
  - MST_DATA_BITW > SLV_DATA_BITW.
- Derived values:
  - N = MST_DATA_BITW / SLV_DATA_BITW
  - MB = MST_DATA_BITW / 8
  - SB = SLV_DATA_BITW / 8
- Clk_CI  in  1  clock; all state updates on the rising edge.
- Rst_RBI  in  1  asynchronous, active-low reset.
- Req_SI  in  1  master request.
- Gnt_SO  out  1  request accepted when Req_SI && Gnt_SO.
- Addr_DI  in  ADDR_BITW  master byte address; the low log2(MB) bits are ignored.
- WrEn_SI  in  MB  byte write enables; all zero means a read.
- Wr_DI  in  MST_DATA_BITW  write data.
- RspValid_SO  out  1  response valid.
- RspReady_SI  in  1  response accepted when RspValid_SO && RspReady_SI.
- Rd_DO  out  MST_DATA_BITW  read data; for writes it returns the old contents.
- Slv_En_SO  out  1  BRAM enable.
- Slv_Addr_DO  out  ADDR_BITW  BRAM byte address.
- Slv_WrEn_SO  out  SB  BRAM byte write enables.
- Slv_Wr_DO  out  SLV_DATA_BITW  BRAM write data.
- Slv_Rd_DI  in  SLV_DATA_BITW  BRAM read data, valid one cycle after the enabled access.

## Operation
- **States:** IDLE, BEAT, DRAIN, RESP.
- **IDLE**
  - Gnt_SO = 1.
  - On Req_SI, latch Addr_DI, WrEn_SI and Wr_DI, clear beat counter k, then go to BEAT.
- **BEAT**
  - Slv_En_SO = 1.
  - Slv_Addr_DO = {Addr[ADDR_BITW-1:log2(MB)], k[log2(N)-1:0], log2(SB) zeros}.
  - Slv_WrEn_SO = latched WrEn[k*SB +: SB].
  - Slv_Wr_DO = latched Wr_D[k*SLV_DATA_BITW +: SLV_DATA_BITW].
  - Increment k. After beat k = N-1, go to DRAIN.
- **Beat behaviour:**
  - Every beat is issued, including beats whose byte-enable slice is zero; those act as reads.
  - Slices are little-endian: beat 0 carries the least-significant slice.
- **Read capture:** in the cycle after beat k, Slv_Rd_DI is captured into Rd_DO[k*SLV_DATA_BITW +: SLV_DATA_BITW]. This happens for beats 0..N-2 during BEAT and for beat N-1 during DRAIN.
- **DRAIN**
  - Slv_En_SO = 0.
  - Capture the last slice, then go to RESP.
- **RESP**
  - RspValid_SO = 1; Rd_DO is stable.
  - Hold until RspReady_SI, then go to IDLE.
  - A new grant is given no earlier than the cycle after the response handshake.
- **Idle slave outputs:** in all states other than BEAT, Slv_En_SO, Slv_WrEn_SO and Slv_Addr_DO are 0.
- **Address wrap:** Slv_Addr_DO never exceeds the master word's aligned range, so there is no wrap across master words. The address space wraps modulo 2^ADDR_BITW implicitly.

## Timing
- **Reset** (Rst_RBI low, asynchronous):
  - state = IDLE, k = 0.
  - Gnt_SO = 0 (gated with the reset), RspValid_SO = 0, Rd_DO = 0.
  - All Slv_* outputs are 0.
- **Latency:** with the handshake in cycle 0:
  - beats occur in cycles 1..N;
  - DRAIN is in cycle N+1;
  - RspValid_SO rises in cycle N+2.
- **Throughput:** minimum period per access is N+3 cycles when RspReady_SI is held high.
- **Reset mid-operation:**
  - Slv_En_SO and Slv_WrEn_SO drop immediately; no response is issued.
  - Slices already written remain in the BRAM; this partial write is accepted behaviour.
- **Ignored inputs:**
  - Req_SI outside IDLE is ignored.
  - Master inputs may change freely after the grant, because they are latched.
- **Handshake rule:** RspValid_SO never depends combinationally on RspReady_SI.

## Test plan
- **Read, N=4:**
  - Stimulus: BRAM preloaded with words 0x0..0x3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; read at Addr 0x0.
  - Response: Slv_Addr_DO = 0x0, 0x4, 0x8, 0xC in cycles 1-4; RspValid_SO in cycle 6; Rd_DO = 0x44444444_33333333_22222222_11111111.
- **Partial write:**
  - Stimulus: Addr 0x10, WrEn 0x00F0, Wr_D slice 1 = 0xDEADBEEF.
  - Response: only the beat at 0x14 has Slv_WrEn_SO = 0xF; a subsequent read of 0x10 returns 0xDEADBEEF in bits [63:32] and the other slices unchanged.
- **Ignored address bits:**
  - Stimulus: Addr 0x1F.
  - Response: beats go to 0x10, 0x14, 0x18, 0x1C.
- **Backpressure:**
  - Stimulus: RspReady_SI low for 3 cycles after RspValid_SO rises; Req_SI held high throughout.
  - Response: Rd_DO stable; Gnt_SO stays 0 until the cycle after RspReady_SI goes high.
- **Back-to-back:**
  - Stimulus: two reads with RspReady_SI tied high.
  - Response: the second grant occurs exactly 7 cycles after the first.
- **Reset mid-burst:**
  - Stimulus: deassert Rst_RBI during beat 2 of a write.
  - Response: Slv_En_SO = 0 immediately; no RspValid_SO; after reset is released, Gnt_SO = 1; BRAM holds slices 0-1 new and slices 2-3 old.
